// File: rtl/edge_event_shaper.sv
// edge_event_shaper
// Turns single-cycle source events into a registered level train: one
// high-then-low pulse per event, with minimum high and low widths so every
// falling edge survives a downstream falling-edge resynchroniser.
// Bursts are queued in a saturating pending counter; lost events set a
// sticky ovf flag.
//
// Optional build macro: SHAPER_DROP_CNT_EN adds an 8-bit saturating count
// of dropped events (drop_cnt), cleared by clr_ovf.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | level low, nothing in flight, waiting for an event/backlog
// HIGH   | level high for HIGH_CYC cycles
// LOW    | level low for LOW_CYC cycles (guaranteed gap before next)

module edge_event_shaper #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int CNT_W    = 4
) (
    input  logic             srcclk,
    input  logic             srcreset,
    input  logic             evt_pulse,
    input  logic             clr_ovf,
    output logic             level_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
`ifdef SHAPER_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             ovf
);

    localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    // Keep at least one bit so HIGH_CYC=LOW_CYC=1 still builds.
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic             want;
    logic             consume;
    logic             drop;

    // An event is available either from this cycle's pulse or the backlog.
    assign want = evt_pulse | (pend_q != '0);

    // State and timer registers.
    always_ff @(posedge srcclk or posedge srcreset) begin
        if (srcreset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state and timer logic; flags the cycle in which an event is started.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        consume = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (want) begin
                    state_d = S_HIGH;
                    timer_d = HIGH_LOAD;
                    consume = 1'b1;
                end
            end
            S_HIGH: begin
                if (timer_q == '0) begin
                    state_d = S_LOW;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_LOW: begin
                if (timer_q == '0) begin
                    // Back-to-back under backlog: skip IDLE so the period is
                    // exactly HIGH_CYC+LOW_CYC.
                    if (want) begin
                        state_d = S_HIGH;
                        timer_d = HIGH_LOAD;
                        consume = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output decode from the next state, so level_out is a plain flop output.
    always_comb begin
        level_d = (state_d == S_HIGH);
    end

    // Output register feeding the resynchroniser.
    always_ff @(posedge srcclk or posedge srcreset) begin
        if (srcreset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    // Pending counter arithmetic: consume takes from the backlog first; a
    // consume with an empty backlog is the current pulse bypassing the queue.
    always_comb begin
        pend_d = pend_q;
        drop   = 1'b0;
        if (consume) begin
            if ((pend_q != '0) && !evt_pulse) begin
                pend_d = pend_q - CNT_W'(1);
            end
        end else if (evt_pulse) begin
            if (pend_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end
        // A drop in the same cycle as a clear wins.
        ovf_d = drop | (ovf_q & ~clr_ovf);
    end

    // Pending counter and sticky overflow registers.
    always_ff @(posedge srcclk or posedge srcreset) begin
        if (srcreset) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef SHAPER_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating drop counter, cleared by clr_ovf unless a drop coincides.
    always_comb begin
        drop_d = drop_q;
        if (drop) begin
            if (clr_ovf) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (clr_ovf) begin
            drop_d = 8'd0;
        end
    end

    // Drop counter register.
    always_ff @(posedge srcclk or posedge srcreset) begin
        if (srcreset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign level_out = level_q;
    assign busy      = (state_q != S_IDLE);
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_shaper.sv
// Directed bench for edge_event_shaper at default parameters
// (HIGH_CYC=4, LOW_CYC=4, CNT_W=4). Cycle c is the interval after rising
// edge c; inputs set in cycle c are sampled at edge c+1.

module tb_edge_event_shaper;

    logic       srcclk = 1'b0;
    logic       srcreset;
    logic       evt_pulse;
    logic       clr_ovf;
    logic       level_out;
    logic       busy;
    logic [3:0] pending;
    logic       ovf;
`ifdef SHAPER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    edge_event_shaper #(
        .HIGH_CYC(4),
        .LOW_CYC (4),
        .CNT_W   (4)
    ) dut (
        .srcclk   (srcclk),
        .srcreset (srcreset),
        .evt_pulse(evt_pulse),
        .clr_ovf  (clr_ovf),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
`ifdef SHAPER_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .ovf      (ovf)
    );

    always #5 srcclk = ~srcclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge srcclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        srcreset  = 1'b1;
        evt_pulse = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge srcclk);
        #1;
        srcreset = 1'b0;
        cyc      = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
`ifdef SHAPER_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Scenario 1: single event at cycle 10
        while (cyc <= 20) begin
            evt_pulse = (cyc == 10);
            chk("s1_level", 32'(level_out), 32'((cyc >= 11) && (cyc <= 14)));
            chk("s1_busy", 32'(busy), 32'((cyc >= 11) && (cyc <= 18)));
            chk("s1_pending", 32'(pending), 32'd0);
            step();
        end

        // Scenario 2: events at 10,11,12 queue and drain every 8 cycles
        do_reset();
        while (cyc <= 36) begin
            evt_pulse = (cyc >= 10) && (cyc <= 12);
            chk("s2_level", 32'(level_out),
                32'(((cyc >= 11) && (cyc <= 14)) || ((cyc >= 19) && (cyc <= 22)) ||
                    ((cyc >= 27) && (cyc <= 30))));
            if (cyc >= 12)
                chk("s2_pending", 32'(pending),
                    (cyc == 12) ? 32'd1 : (cyc <= 18) ? 32'd2 : (cyc <= 26) ? 32'd1 : 32'd0);
            chk("s2_busy", 32'(busy), 32'((cyc >= 11) && (cyc <= 34)));
            step();
        end

        // Scenario 3: second event exactly at LOW terminal count
        do_reset();
        while (cyc <= 27) begin
            evt_pulse = (cyc == 10) || (cyc == 18);
            if (cyc >= 11) begin
                chk("s3_level", 32'(level_out),
                    32'(((cyc >= 11) && (cyc <= 14)) || ((cyc >= 19) && (cyc <= 22))));
                chk("s3_busy", 32'(busy), 32'(cyc <= 26));
                chk("s3_pending", 32'(pending), 32'd0);
            end
            step();
        end

        // Scenario 4: evt_pulse held for 40 cycles (10..49), saturation and drain
        do_reset();
        while (cyc <= 175) begin
            evt_pulse = (cyc >= 10) && (cyc <= 49);
            case (cyc)
                18: chk("s4_pending18", 32'(pending), 32'd7);
                27: chk("s4_pending27", 32'(pending), 32'd14);
                28: begin
                    chk("s4_pending28", 32'(pending), 32'd15);
                    chk("s4_ovf28", 32'(ovf), 32'd0);
                end
                29: chk("s4_ovf29", 32'(ovf), 32'd1);
                35: chk("s4_pending35", 32'(pending), 32'd15);
                50: begin
                    chk("s4_pending50", 32'(pending), 32'd15);
                    chk("s4_level50", 32'(level_out), 32'd0);
                end
                51: begin
                    chk("s4_pending51", 32'(pending), 32'd14);
                    chk("s4_level51", 32'(level_out), 32'd1);
                end
                55: chk("s4_level55", 32'(level_out), 32'd0);
                59: chk("s4_level59", 32'(level_out), 32'd1);
                60: begin
                    chk("s4_ovf60", 32'(ovf), 32'd1);
`ifdef SHAPER_DROP_CNT_EN
                    chk("s4_drop_cnt", 32'(drop_cnt), 32'd20);
`endif
                end
                162: chk("s4_pending162", 32'(pending), 32'd1);
                163: begin
                    chk("s4_pending163", 32'(pending), 32'd0);
                    chk("s4_level163", 32'(level_out), 32'd1);
                end
                170: chk("s4_busy170", 32'(busy), 32'd1);
                171: chk("s4_busy171", 32'(busy), 32'd0);
                default: ;
            endcase
            step();
        end

        // Scenario 5a: clear with no drop
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("s5_ovf_cleared", 32'(ovf), 32'd0);

        // Scenario 5b: saturate again, then clear coincident with a drop
        do_reset();
        while (cyc <= 23) begin
            evt_pulse = ((cyc >= 1) && (cyc <= 19)) || (cyc == 21);
            clr_ovf   = (cyc >= 20) && (cyc <= 22);
            case (cyc)
                19: begin
                    chk("s5_pending19", 32'(pending), 32'd15);
                    chk("s5_ovf19", 32'(ovf), 32'd0);
                end
                20: chk("s5_ovf20", 32'(ovf), 32'd1);
                21: chk("s5_ovf21", 32'(ovf), 32'd0);
                22: chk("s5_ovf_set_dominant", 32'(ovf), 32'd1);
                23: chk("s5_ovf23", 32'(ovf), 32'd0);
                default: ;
            endcase
`ifdef SHAPER_DROP_CNT_EN
            if (cyc == 20) chk("s5_drop20", 32'(drop_cnt), 32'd1);
            if (cyc == 21) chk("s5_drop21", 32'(drop_cnt), 32'd0);
            if (cyc == 22) chk("s5_drop22", 32'(drop_cnt), 32'd1);
`endif
            step();
        end
        clr_ovf = 1'b0;

        // Scenario 6: reset mid-HIGH with backlog
        do_reset();
        while (cyc < 13) begin
            evt_pulse = (cyc >= 10) && (cyc <= 12);
            step();
        end
        evt_pulse = 1'b0;
        chk("s6_pre_pending", 32'(pending), 32'd2);
        chk("s6_pre_level", 32'(level_out), 32'd1);
        srcreset = 1'b1;
        #1;
        chk("s6_rst_level", 32'(level_out), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_pending", 32'(pending), 32'd0);
        do_reset();
        while (cyc <= 20) begin
            evt_pulse = (cyc == 10);
            chk("s6_level", 32'(level_out), 32'((cyc >= 11) && (cyc <= 14)));
            chk("s6_busy", 32'(busy), 32'((cyc >= 11) && (cyc <= 18)));
            chk("s6_pending", 32'(pending), 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
